// File: rtl/dec_24_pkg.sv
// Shared definitions for the registered 2-to-4 decoder.
//   SEL_W   : width of the select index {a,b}
//   OUT_W   : width of the decoded output
//   onehot4 : maps a 2-bit index to its one-hot 4-bit pattern
//             (00 -> 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000)
package dec_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 4;

  function automatic logic [OUT_W-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [OUT_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dec_24.sv
// Registered 2-to-4 line decoder with enable, valid flag and change pulse.
//
// Ports:
//   clk     in   system clock, all state updates on the rising edge
//   rst     in   synchronous active-high reset, priority over all inputs
//   a       in   select MSB
//   b       in   select LSB
//   en      in   decode enable
//   y       out  [3:0] registered one-hot decode of {a,b}; inverted when ACTIVE_LOW
//   y_valid out  registered copy of en
//   y_chg   out  one-cycle pulse when the decoded line differs from the last
//                enabled decode since reset
//
// Parameter:
//   ACTIVE_LOW  when 1, every bit of y is inverted (selected line = 0);
//               y_valid and y_chg keep their active-high sense.
//
// Interface timing: en qualifies {a,b} on the same rising edge; there is no
// back-pressure. Outputs reflect the inputs sampled one edge earlier, with no
// combinational path from any input to any output.
module dec_24
  import dec_pkg::*;
#(
  parameter logic ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic             y_chg
);

  // Pattern shown on y when no line is selected.
  localparam logic [OUT_W-1:0] IDLE_PAT = {OUT_W{ACTIVE_LOW}};

  logic [SEL_W-1:0] idx;
  logic [OUT_W-1:0] y_q;
  logic             valid_q;
  logic             chg_q;
  logic [SEL_W-1:0] prev_idx;
  logic             prev_vld;

  assign idx = {a, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= IDLE_PAT;
      valid_q  <= 1'b0;
      chg_q    <= 1'b0;
      prev_idx <= '0;
      prev_vld <= 1'b0;
    end else if (en) begin
      // XOR with the idle pattern flips polarity only in active-low builds.
      y_q      <= onehot4(idx) ^ IDLE_PAT;
      valid_q  <= 1'b1;
      chg_q    <= prev_vld && (idx != prev_idx);
      prev_idx <= idx;
      prev_vld <= 1'b1;
    end else begin
      // Disabled cycles leave prev_idx/prev_vld alone so the next enabled
      // decode is compared against the last enabled one.
      y_q      <= IDLE_PAT;
      valid_q  <= 1'b0;
      chg_q    <= 1'b0;
    end
  end

  assign y       = y_q;
  assign y_valid = valid_q;
  assign y_chg   = chg_q;

endmodule

// File: tb/tb_dec_24.sv
module tb_dec_24;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       en;
  logic [3:0] y_hi;
  logic       v_hi;
  logic       c_hi;
  logic [3:0] y_lo;
  logic       v_lo;
  logic       c_lo;

  int total;
  int passed;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #50 clk = ~clk;

  dec_24 #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .y(y_hi), .y_valid(v_hi), .y_chg(c_hi)
  );

  dec_24 #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .y(y_lo), .y_valid(v_lo), .y_chg(c_lo)
  );

  // ---------------- checking ----------------
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // ---------------- driver ----------------
  // Apply inputs, clock one edge, then check outputs 1 time unit later.
  // ey is the active-high expectation; the active-low copy must be its inverse.
  task automatic step(input string tag, input logic ia, input logic ib,
                      input logic ien, input logic irst,
                      input logic [3:0] ey, input logic ev, input logic ec);
    a   = ia;
    b   = ib;
    en  = ien;
    rst = irst;
    @(posedge clk);
    #1;
    check_vec({tag, ".y"},        y_hi, ey);
    check_bit({tag, ".y_valid"},  v_hi, ev);
    check_bit({tag, ".y_chg"},    c_hi, ec);
    check_vec({tag, ".y_al"},     y_lo, ey ^ 4'b1111);
    check_bit({tag, ".y_valid_al"}, v_lo, ev);
    check_bit({tag, ".y_chg_al"}, c_lo, ec);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    total  = 0;
    passed = 0;
    a = 1'b0; b = 1'b0; en = 1'b0; rst = 1'b1;

    // reset held two cycles with all inputs high
    step("rst0", 1, 1, 1, 1, 4'b0000, 0, 0);
    step("rst1", 1, 1, 1, 1, 4'b0000, 0, 0);

    // exhaustive sweep
    step("sw00", 0, 0, 1, 0, 4'b0001, 1, 0);
    step("sw01", 0, 1, 1, 0, 4'b0010, 1, 1);
    step("sw10", 1, 0, 1, 0, 4'b0100, 1, 1);
    step("sw11", 1, 1, 1, 0, 4'b1000, 1, 1);

    // lock-step toggling from reset
    step("ls_rst", 0, 0, 1, 1, 4'b0000, 0, 0);
    step("ls0",    0, 0, 1, 0, 4'b0001, 1, 0);
    step("ls1",    1, 1, 1, 0, 4'b1000, 1, 1);
    step("ls2",    0, 0, 1, 0, 4'b0001, 1, 1);
    step("ls3",    1, 1, 1, 0, 4'b1000, 1, 1);

    // enable gap: comparison is against last enabled index (10)
    step("gap0", 1, 0, 1, 0, 4'b0100, 1, 1);
    step("gap1", 0, 1, 0, 0, 4'b0000, 0, 0);
    step("gap2", 0, 1, 0, 0, 4'b0000, 0, 0);
    step("gap3", 0, 1, 0, 0, 4'b0000, 0, 0);
    step("gap4", 1, 0, 1, 0, 4'b0100, 1, 0);

    // reset mid-stream
    step("mid0", 1, 1, 1, 0, 4'b1000, 1, 1);
    step("mid1", 1, 1, 1, 1, 4'b0000, 0, 0);
    step("mid2", 1, 1, 1, 0, 4'b1000, 1, 0);

    // disabled cycle right after reset: still no prior decode
    step("pre_rst", 0, 0, 0, 1, 4'b0000, 0, 0);
    step("pre_dis", 0, 0, 0, 0, 4'b0000, 0, 0);
    step("pre_en",  1, 0, 1, 0, 4'b0100, 1, 0);

    // hold index constant for five cycles (previous enabled idx was 10)
    step("hold0", 0, 1, 1, 0, 4'b0010, 1, 1);
    step("hold1", 0, 1, 1, 0, 4'b0010, 1, 0);
    step("hold2", 0, 1, 1, 0, 4'b0010, 1, 0);
    step("hold3", 0, 1, 1, 0, 4'b0010, 1, 0);
    step("hold4", 0, 1, 1, 0, 4'b0010, 1, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
